// File: rtl/priority_encoder_pipe.sv
// Two-stage pipelined two-sided priority encoder with valid/ready flow control.
// S1 holds the accepted word. S2 registers the MSB/LSB one-hots, their indices and the zero flag.
module priority_encoder_pipe #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] data_left_o,
    output logic [WIDTH-1:0] data_right_o,
    output logic [IDX_W-1:0] left_idx_o,
    output logic [IDX_W-1:0] right_idx_o,
    output logic             zero_o,
    output logic             data_val_o,
    input  logic             data_ready_i
);

    logic [WIDTH-1:0] s1_data_q;
    logic             s1_val_q;

    logic [WIDTH-1:0] left_q, right_q;
    logic [IDX_W-1:0] left_idx_q, right_idx_q;
    logic             zero_q, val_q;

    logic             s2_can_load;
    logic             s1_load;
    logic [WIDTH-1:0] rev_w, rev_iso;
    logic [WIDTH-1:0] left_d, right_d;
    logic [IDX_W-1:0] left_idx_d, right_idx_d;
    logic             zero_d;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [WIDTH-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (oh[i]) idx |= IDX_W'(i);
        end
        return idx;
    endfunction

    assign s2_can_load  = !val_q || data_ready_i;
    // Combinational path from data_ready_i is deliberate: lets S1 refill while S2 drains.
    assign data_ready_o = srst_n_i && (!s1_val_q || s2_can_load);
    assign s1_load      = data_val_i && data_ready_o;

    always_comb begin
        rev_w  = '0;
        left_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_w[i] = s1_data_q[WIDTH-1-i];
        end
        right_d = s1_data_q & (~s1_data_q + WIDTH'(1));
        // MSB isolation: reverse, isolate the lowest bit, reverse back.
        rev_iso = rev_w & (~rev_w + WIDTH'(1));
        for (int i = 0; i < WIDTH; i++) begin
            left_d[i] = rev_iso[WIDTH-1-i];
        end
        left_idx_d  = onehot_to_idx(left_d);
        right_idx_d = onehot_to_idx(right_d);
        zero_d      = ~|s1_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            s1_data_q   <= '0;
            s1_val_q    <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            left_idx_q  <= '0;
            right_idx_q <= '0;
            zero_q      <= 1'b0;
            val_q       <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_data_q <= data_i;
                s1_val_q  <= 1'b1;
            end else if (s2_can_load) begin
                s1_val_q  <= 1'b0;
            end
            if (s2_can_load) begin
                val_q <= s1_val_q;
                // Data outputs keep their last value when a bubble moves into S2.
                if (s1_val_q) begin
                    left_q      <= left_d;
                    right_q     <= right_d;
                    left_idx_q  <= left_idx_d;
                    right_idx_q <= right_idx_d;
                    zero_q      <= zero_d;
                end
            end
        end
    end

    assign data_left_o  = left_q;
    assign data_right_o = right_q;
    assign left_idx_o   = left_idx_q;
    assign right_idx_o  = right_idx_q;
    assign zero_o       = zero_q;
    assign data_val_o   = val_q;

endmodule

// File: tb/tb_priority_encoder_pipe.sv
// Bench for priority_encoder_pipe: directed cases at WIDTH 16 and 5, random soak at 32 and 64
// checked against a bit-scan reference model and a queue of accepted words.
module tb_priority_encoder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srst_n;

    logic [15:0] d16, l16, r16;
    logic [3:0]  li16, ri16;
    logic        v16_i, rdy16_o, z16, v16_o, rdy16_i;

    logic [4:0]  d5, l5, r5;
    logic [2:0]  li5, ri5;
    logic        v5_i, rdy5_o, z5, v5_o, rdy5_i;

    logic [63:0] ds;
    logic        vs_i, rs_i;
    logic [31:0] l32, r32;
    logic [4:0]  li32, ri32;
    logic        rdy32_o, z32, v32_o;
    logic [63:0] l64, r64;
    logic [5:0]  li64, ri64;
    logic        rdy64_o, z64, v64_o;

    int vectors = 0;
    int miscompares = 0;

    priority_encoder_pipe #(.WIDTH(16)) u_dut16 (
        .clk_i(clk), .srst_n_i(srst_n), .data_i(d16), .data_val_i(v16_i),
        .data_ready_o(rdy16_o), .data_left_o(l16), .data_right_o(r16),
        .left_idx_o(li16), .right_idx_o(ri16), .zero_o(z16), .data_val_o(v16_o),
        .data_ready_i(rdy16_i)
    );

    priority_encoder_pipe #(.WIDTH(5)) u_dut5 (
        .clk_i(clk), .srst_n_i(srst_n), .data_i(d5), .data_val_i(v5_i),
        .data_ready_o(rdy5_o), .data_left_o(l5), .data_right_o(r5),
        .left_idx_o(li5), .right_idx_o(ri5), .zero_o(z5), .data_val_o(v5_o),
        .data_ready_i(rdy5_i)
    );

    priority_encoder_pipe #(.WIDTH(32)) u_dut32 (
        .clk_i(clk), .srst_n_i(srst_n), .data_i(ds[31:0]), .data_val_i(vs_i),
        .data_ready_o(rdy32_o), .data_left_o(l32), .data_right_o(r32),
        .left_idx_o(li32), .right_idx_o(ri32), .zero_o(z32), .data_val_o(v32_o),
        .data_ready_i(rs_i)
    );

    priority_encoder_pipe #(.WIDTH(64)) u_dut64 (
        .clk_i(clk), .srst_n_i(srst_n), .data_i(ds), .data_val_i(vs_i),
        .data_ready_o(rdy64_o), .data_left_o(l64), .data_right_o(r64),
        .left_idx_o(li64), .right_idx_o(ri64), .zero_o(z64), .data_val_o(v64_o),
        .data_ready_i(rs_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int hi_idx(input logic [63:0] w, input int width);
        for (int i = width - 1; i >= 0; i--) if (w[i]) return i;
        return -1;
    endfunction

    function automatic int lo_idx(input logic [63:0] w, input int width);
        for (int i = 0; i < width; i++) if (w[i]) return i;
        return -1;
    endfunction

    task automatic chk_res(input string tag, input int width, input logic [63:0] w,
                           input logic [63:0] left, input logic [63:0] right,
                           input int lidx, input int ridx, input logic zero, input logic val);
        int h, l;
        h = hi_idx(w, width);
        l = lo_idx(w, width);
        chk({tag, "_val"},   val, 1'b1);
        chk({tag, "_left"},  left,  (h < 0) ? 64'd0 : (64'd1 << h));
        chk({tag, "_right"}, right, (l < 0) ? 64'd0 : (64'd1 << l));
        chk({tag, "_lidx"},  lidx,  (h < 0) ? 0 : h);
        chk({tag, "_ridx"},  ridx,  (l < 0) ? 0 : l);
        chk({tag, "_zero"},  zero,  h < 0);
        chk({tag, "_onehot"}, {$onehot0(left), $onehot0(right)}, 2'b11);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] gen_word();
        case ($urandom % 4)
            0:       return 64'd0;
            1:       return 64'd1 << ($urandom % 64);
            2:       return {$urandom, $urandom};
            default: return {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [15:0] bp_words[4];
        logic [63:0] q[$];
        int wi, oi, acc;
        bp_words = '{16'h1234, 16'h8000, 16'h0001, 16'h0000};

        srst_n = 1'b0;
        d16 = '0; v16_i = 1'b0; rdy16_i = 1'b1;
        d5 = '0;  v5_i = 1'b0;  rdy5_i = 1'b1;
        ds = '0;  vs_i = 1'b0;  rs_i = 1'b1;
        tick(); tick();
        chk("rst_val", v16_o, 1'b0);
        chk("rst_ready_low", rdy16_o, 1'b0);
        chk("rst_left", l16, 16'h0);
        chk("rst_right", r16, 16'h0);
        chk("rst_idx", {li16, ri16}, 8'h0);
        chk("rst_zero", z16, 1'b0);
        srst_n = 1'b1;
        #1;
        chk("ready_after_release", rdy16_o, 1'b1);

        // Single word, latency two edges
        d16 = 16'h0A50; v16_i = 1'b1;
        tick();
        v16_i = 1'b0;
        #1;
        chk("lat_not_yet", v16_o, 1'b0);
        tick();
        chk_res("w0A50", 16, 64'h0A50, l16, r16, li16, ri16, z16, v16_o);

        // Back-to-back: results on consecutive cycles
        d16 = 16'h8001; v16_i = 1'b1;
        tick();
        d16 = 16'h0000;
        tick();
        chk_res("w8001", 16, 64'h8001, l16, r16, li16, ri16, z16, v16_o);
        d16 = 16'h0040;
        tick();
        chk_res("w0000", 16, 64'h0000, l16, r16, li16, ri16, z16, v16_o);
        v16_i = 1'b0;
        tick();
        chk_res("w0040", 16, 64'h0040, l16, r16, li16, ri16, z16, v16_o);
        tick();
        chk("bubble_val", v16_o, 1'b0);
        chk("bubble_hold_left", l16, 16'h0040);

        // Backpressure: 5 stalled cycles with 4 words offered
        wi = 0;
        oi = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            rdy16_i = (cyc >= 5);
            v16_i   = (wi < 4);
            d16     = bp_words[(wi < 4) ? wi : 3];
            #1;
            if (cyc == 4) begin
                chk("bp_accepted", wi, 2);
                chk("bp_ready_low", rdy16_o, 1'b0);
            end
            if (v16_o && !rdy16_i)
                chk_res("bp_hold", 16, {48'd0, bp_words[0]}, l16, r16, li16, ri16, z16, v16_o);
            if (v16_o && rdy16_i) begin
                if (oi < 4)
                    chk_res("bp_out", 16, {48'd0, bp_words[oi]}, l16, r16, li16, ri16, z16, v16_o);
                oi++;
            end
            if (v16_i && rdy16_o) wi++;
            tick();
        end
        chk("bp_out_count", oi, 4);

        // Reset with both stages full
        rdy16_i = 1'b0; v16_i = 1'b1; d16 = 16'hF0F0;
        tick();
        d16 = 16'h0F0F;
        tick();
        v16_i = 1'b0;
        #1;
        chk("full_val", v16_o, 1'b1);
        chk("full_ready", rdy16_o, 1'b0);
        srst_n = 1'b0;
        tick();
        chk("mrst_val", v16_o, 1'b0);
        chk("mrst_masks", {l16, r16}, 32'h0);
        chk("mrst_idx", {li16, ri16, z16}, 9'h0);
        chk("mrst_ready_low", rdy16_o, 1'b0);
        srst_n = 1'b1; rdy16_i = 1'b1;
        #1;
        chk("mrst_ready_release", rdy16_o, 1'b1);
        tick(); tick();
        chk("mrst_flushed", v16_o, 1'b0);

        // Non-power-of-two width
        d5 = 5'b10110; v5_i = 1'b1;
        tick();
        v5_i = 1'b0;
        tick();
        chk_res("w5", 5, 64'b10110, l5, r5, li5, ri5, z5, v5_o);

        // Random soak on the 32- and 64-bit instances sharing one stream
        acc = 0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            vs_i = (acc < 10000) && ($urandom % 4 != 0);
            rs_i = (acc >= 10000) || ($urandom % 4 != 0);
            ds   = gen_word();
            #1;
            if (v64_o) begin
                if (q.size() == 0) begin
                    chk("soak_spurious", v64_o, 1'b0);
                end else begin
                    chk_res("s64", 64, q[0], l64, r64, li64, ri64, z64, v64_o);
                    chk_res("s32", 32, {32'd0, q[0][31:0]}, {32'd0, l32}, {32'd0, r32},
                            li32, ri32, z32, v32_o);
                    if (rs_i) void'(q.pop_front());
                end
            end
            if (vs_i && rdy64_o) begin
                q.push_back(ds);
                acc++;
            end
            if (acc >= 10000 && q.size() == 0 && !v64_o) break;
            tick();
        end
        chk("soak_count", acc, 10000);
        chk("soak_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
